// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer.
package ov7670_cfg_pkg;

  typedef enum logic [3:0] {
    ST_POWERUP,
    ST_REWIND,
    ST_SETTLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_RETRY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } cfg_state_t;

  localparam logic [7:0]  COM7_ADDR      = 8'h12;
  localparam int          COM7_RESET_BIT = 7;
  localparam logic [15:0] CFG_END        = 16'hFFFF;
  localparam logic [7:0]  SCCB_WRITE_ID  = 8'h42;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // A COM7 write with the reset bit set needs the long post-reset wait.
  function automatic logic is_com7_reset(logic [7:0] addr, logic [7:0] data);
    return (addr == COM7_ADDR) && data[COM7_RESET_BIT];
  endfunction

endpackage

// File: rtl/ov7670_cfg_sequencer_if.sv
// Write-request channel between the configuration sequencer and the SCCB master.
interface ov7670_cfg_sequencer_if;
  // sccb_valid rises with addr/data/id stable and stays high, unchanged, until
  // the cycle where sccb_valid & sccb_ready is seen; that cycle is the transfer.
  // sccb_done pulses once per transfer; sccb_nack is only meaningful with it.
  logic       sccb_valid;
  logic       sccb_ready;
  logic [7:0] sccb_id;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_data;
  logic       sccb_done;
  logic       sccb_nack;

  modport master (
    output sccb_valid, sccb_id, sccb_addr, sccb_data,
    input  sccb_ready, sccb_done, sccb_nack
  );

  modport slave (
    input  sccb_valid, sccb_id, sccb_addr, sccb_data,
    output sccb_ready, sccb_done, sccb_nack
  );
endinterface

// File: rtl/ov7670_cfg_sequencer_cfg_delay_timer.sv
// Down-counter shared by the power-up, settle and gap waits.
module cfg_delay_timer #(
  parameter int             W          = 8,
  parameter logic [W-1:0]   RESET_LOAD = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Loading N-1 makes the wait state last exactly N cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= RESET_LOAD;
    else if (start)
      cnt <= load;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0) && !start;

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// Walks the OV7670 register table, issuing SCCB writes with the required delays and retries.
module ov7670_cfg_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter logic [7:0] CAM_ID            = SCCB_WRITE_ID,
  parameter int         POWERUP_CYCLES    = 1_250_000,
  parameter int         RESET_WAIT_CYCLES = 25_000,
  parameter int         GAP_CYCLES        = 250,
  parameter int         MAX_RETRY         = 3,
  parameter int         SETTLE_CYCLES     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reconfig,
  input  logic [15:0] command,
  input  logic        finished,
  output logic        advance,
  output logic        resend,
  ov7670_cfg_sequencer_if.master sccb,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  entry_cnt,
  output cfg_state_t  state_dbg
);

  localparam int MAX_DELAY = max2(max2(POWERUP_CYCLES, RESET_WAIT_CYCLES),
                                  max2(GAP_CYCLES, SETTLE_CYCLES));
  localparam int TW = $clog2(MAX_DELAY) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [TW-1:0] LD_POWERUP = TW'(POWERUP_CYCLES - 1);
  localparam logic [TW-1:0] LD_RESET   = TW'(RESET_WAIT_CYCLES - 1);
  localparam logic [TW-1:0] LD_GAP     = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] LD_SETTLE  = TW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  cfg_state_t    state, state_n;
  logic [7:0]    addr_q, data_q;
  logic [RW-1:0] retry_q;
  logic [7:0]    entry_q;

  logic          tmr_start;
  logic [TW-1:0] tmr_load;
  logic          tmr_expired;
  logic          latch_cmd, inc_entry, inc_retry, clr_entry;

  cfg_delay_timer #(
    .W          (TW),
    .RESET_LOAD (LD_POWERUP)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (tmr_start),
    .load    (tmr_load),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_POWERUP;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    tmr_start = 1'b0;
    tmr_load  = LD_SETTLE;
    latch_cmd = 1'b0;
    inc_entry = 1'b0;
    inc_retry = 1'b0;
    clr_entry = 1'b0;
    case (state)
      ST_POWERUP: begin
        // reconfig is deliberately not looked at until the table has run once.
        if (tmr_expired) state_n = ST_REWIND;
      end
      ST_REWIND: begin
        tmr_start = 1'b1;
        tmr_load  = LD_SETTLE;
        state_n   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_expired) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        if (finished) begin
          state_n = ST_DONE;
        end else begin
          latch_cmd = 1'b1;
          state_n   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sccb.sccb_ready) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (sccb.sccb_done) begin
          if (!sccb.sccb_nack) begin
            inc_entry = 1'b1;
            tmr_start = 1'b1;
            tmr_load  = is_com7_reset(addr_q, data_q) ? LD_RESET : LD_GAP;
            state_n   = ST_GAP;
          end else if (retry_q < RETRY_MAX) begin
            inc_retry = 1'b1;
            tmr_start = 1'b1;
            tmr_load  = LD_GAP;
            state_n   = ST_RETRY;
          end else begin
            state_n = ST_ERROR;
          end
        end
      end
      ST_GAP: begin
        if (tmr_expired) state_n = ST_NEXT;
      end
      ST_RETRY: begin
        if (tmr_expired) state_n = ST_ISSUE;
      end
      ST_NEXT: begin
        tmr_start = 1'b1;
        tmr_load  = LD_SETTLE;
        state_n   = ST_SETTLE;
      end
      ST_DONE, ST_ERROR: begin
        if (reconfig) begin
          clr_entry = 1'b1;
          state_n   = ST_REWIND;
        end
      end
      default: state_n = ST_POWERUP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      data_q  <= '0;
      retry_q <= '0;
      entry_q <= '0;
    end else begin
      if (latch_cmd) begin
        addr_q  <= command[15:8];
        data_q  <= command[7:0];
        retry_q <= '0;
      end else if (inc_retry) begin
        retry_q <= retry_q + 1'b1;
      end
      if (clr_entry)
        entry_q <= '0;
      else if (inc_entry && entry_q != 8'hFF)
        entry_q <= entry_q + 1'b1;
    end
  end

  assign sccb.sccb_valid = (state == ST_ISSUE);
  assign sccb.sccb_id    = CAM_ID;
  assign sccb.sccb_addr  = addr_q;
  assign sccb.sccb_data  = data_q;

  assign advance   = (state == ST_NEXT);
  assign resend    = (state == ST_REWIND);
  assign done      = (state == ST_DONE);
  assign error     = (state == ST_ERROR);
  // Gated by reset so that every status output reads 0 while reset is held.
  assign busy      = !reset && (state != ST_DONE) && (state != ST_ERROR);
  assign entry_cnt = entry_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Bench for ov7670_cfg_sequencer: model ROM, model SCCB slave, scoreboarded writes and advance latency.
module tb_ov7670_cfg_sequencer;
  import ov7670_cfg_pkg::*;

  localparam int POWERUP = 10;
  localparam int RST_WAIT = 20;
  localparam int GAP = 4;
  localparam int SETTLE = 3;

  logic        clk;
  logic        reset;
  logic        reconfig;
  logic [15:0] command;
  logic        finished;
  logic        advance, resend, busy, done, error;
  logic [7:0]  entry_cnt;
  cfg_state_t  state_dbg;

  ov7670_cfg_sequencer_if sif();

  ov7670_cfg_sequencer #(
    .CAM_ID            (8'h42),
    .POWERUP_CYCLES    (POWERUP),
    .RESET_WAIT_CYCLES (RST_WAIT),
    .GAP_CYCLES        (GAP),
    .MAX_RETRY         (2),
    .SETTLE_CYCLES     (SETTLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reconfig  (reconfig),
    .command   (command),
    .finished  (finished),
    .advance   (advance),
    .resend    (resend),
    .sccb      (sif),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .entry_cnt (entry_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model ROM ----------------
  logic [15:0] rom [0:3];
  logic [2:0]  rom_addr;
  logic        resend_d;
  initial begin
    rom[0] = 16'h1280;
    rom[1] = 16'h1204;
    rom[2] = 16'h1100;
    rom[3] = 16'hFFFF;
  end

  // The ROM rewinds on the falling edge of resend.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      resend_d <= 1'b0;
    end else begin
      resend_d <= resend;
      if (resend_d && !resend) rom_addr <= '0;
      else if (advance && rom_addr < 3'd4) rom_addr <= rom_addr + 3'd1;
    end
  end

  assign command  = (rom_addr < 3'd4) ? rom[rom_addr[1:0]] : 16'hFFFF;
  assign finished = (command == 16'hFFFF);

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int          lat_q[$];
  int done_cyc = 0;
  int adv_cnt = 0;
  int resend_cnt = 0;
  int mark_cyc = 0;
  int first_delta = -1;

  int hold_cycles = 0;
  int nack_left = 0;
  int done_delay = 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SCCB slave model + write scoreboard ----------------
  initial begin : sccb_model
    logic [15:0] seen;
    logic        aborted;
    logic        nk;
    sif.sccb_ready = 1'b0;
    sif.sccb_done  = 1'b0;
    sif.sccb_nack  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && sif.sccb_valid) begin
        seen = {sif.sccb_addr, sif.sccb_data};
        for (int i = 0; i < hold_cycles; i++) begin
          @(negedge clk);
          chk("valid_held", {15'd0, sif.sccb_valid}, 32'd1);
          chk("addr_data_stable", {16'd0, sif.sccb_addr, sif.sccb_data}, {16'd0, seen});
        end
        hold_cycles = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual=%04h required=none", seen);
        end else begin
          chk("write_entry", {16'd0, seen}, {16'd0, exp_q.pop_front()});
        end
        chk("write_id", {24'd0, sif.sccb_id}, 32'h42);
        sif.sccb_ready = 1'b1;
        @(negedge clk);
        sif.sccb_ready = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < done_delay; i++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          nk = (seen[15:8] == 8'h11) && (nack_left > 0);
          if (nk) nack_left--;
          else lat_q.push_back(((seen[15:8] == 8'h12) && seen[7]) ? RST_WAIT + 1 : GAP + 1);
          done_cyc = cyc;
          sif.sccb_done = 1'b1;
          sif.sccb_nack = nk;
          @(negedge clk);
          sif.sccb_done = 1'b0;
          sif.sccb_nack = 1'b0;
        end
      end
    end
  end

  // ---------------- advance / resend monitor ----------------
  always @(negedge clk) begin
    if (first_delta < 0 && sif.sccb_valid) first_delta = cyc - mark_cyc;
    if (resend) resend_cnt++;
    if (advance) begin
      adv_cnt++;
      checks++;
      if (lat_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_advance actual=1 required=0 (t=%0t)", $time);
      end else begin
        chk("advance_latency", cyc - done_cyc, lat_q.pop_front());
      end
    end
    if (advance && resend) begin
      checks++; errors++;
      $display("FAIL advance_resend_overlap actual=1 required=0");
    end
    if ((advance || resend) && sif.sccb_valid) begin
      checks++; errors++;
      $display("FAIL rom_ctl_during_valid actual=1 required=0");
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_table(input int nack_copies);
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1204);
    for (int i = 0; i <= nack_copies; i++) exp_q.push_back(16'h1100);
  endtask

  task automatic pulse_reconfig();
    @(negedge clk);
    reconfig = 1'b1;
    @(negedge clk);
    reconfig = 1'b0;
  endtask

  task automatic wait_end(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!(done || error) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!(done || error)) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=busy required=done_or_error", name);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_valid"},   {31'd0, sif.sccb_valid}, 32'd0);
    chk({name, "_advance"}, {31'd0, advance}, 32'd0);
    chk({name, "_resend"},  {31'd0, resend}, 32'd0);
    chk({name, "_busy"},    {31'd0, busy}, 32'd0);
    chk({name, "_done"},    {31'd0, done}, 32'd0);
    chk({name, "_error"},   {31'd0, error}, 32'd0);
    chk({name, "_entry"},   {24'd0, entry_cnt}, 32'd0);
    chk({name, "_addr"},    {24'd0, sif.sccb_addr}, 32'd0);
    chk({name, "_data"},    {24'd0, sif.sccb_data}, 32'd0);
    chk({name, "_id"},      {24'd0, sif.sccb_id}, 32'h42);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int adv_snap, rs_snap, n;
    reconfig = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");

    // Pass 1: power-up, ready held low 7 cycles on the first write, reconfig in POWERUP ignored.
    hold_cycles = 7;
    push_table(0);
    first_delta = -1;
    mark_cyc = cyc;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reconfig = 1'b1;
    @(negedge clk);
    reconfig = 1'b0;
    wait_end("pass1", 2000);
    chk("pass1_powerup_delay", {31'd0, (first_delta >= POWERUP + 1 + SETTLE)}, 32'd1);
    chk("pass1_done", {31'd0, done}, 32'd1);
    chk("pass1_error", {31'd0, error}, 32'd0);
    chk("pass1_busy", {31'd0, busy}, 32'd0);
    chk("pass1_entry_cnt", {24'd0, entry_cnt}, 32'd3);
    chk("pass1_writes_left", exp_q.size(), 32'd0);
    chk("pass1_resends", resend_cnt, 32'd1);

    // Pass 2: reconfig from DONE, no power-up wait; reconfig while busy ignored.
    push_table(0);
    rs_snap = resend_cnt;
    first_delta = -1;
    @(negedge clk);
    mark_cyc = cyc;
    reconfig = 1'b1;
    @(negedge clk);
    reconfig = 1'b0;
    chk("reconfig_resend_high", {31'd0, resend}, 32'd1);
    chk("reconfig_done_clear", {31'd0, done}, 32'd0);
    chk("reconfig_entry_clear", {24'd0, entry_cnt}, 32'd0);
    @(negedge clk);
    chk("reconfig_resend_one_cycle", {31'd0, resend}, 32'd0);
    repeat (12) @(negedge clk);
    pulse_reconfig();
    wait_end("pass2", 2000);
    chk("pass2_no_powerup", {31'd0, (first_delta >= 0 && first_delta <= 8)}, 32'd1);
    chk("pass2_resends", resend_cnt - rs_snap, 32'd1);
    chk("pass2_done", {31'd0, done}, 32'd1);
    chk("pass2_entry_cnt", {24'd0, entry_cnt}, 32'd3);
    chk("pass2_writes_left", exp_q.size(), 32'd0);

    // Pass 3: 11/00 NACKed twice, then ACKed.
    nack_left = 2;
    push_table(2);
    pulse_reconfig();
    wait_end("pass3", 2000);
    chk("pass3_done", {31'd0, done}, 32'd1);
    chk("pass3_error", {31'd0, error}, 32'd0);
    chk("pass3_entry_cnt", {24'd0, entry_cnt}, 32'd3);
    chk("pass3_writes_left", exp_q.size(), 32'd0);

    // Pass 4: 11/00 NACKed three times -> error with the failing entry held.
    nack_left = 3;
    push_table(2);
    pulse_reconfig();
    wait_end("pass4", 2000);
    chk("pass4_error", {31'd0, error}, 32'd1);
    chk("pass4_done", {31'd0, done}, 32'd0);
    chk("pass4_busy", {31'd0, busy}, 32'd0);
    chk("pass4_addr", {24'd0, sif.sccb_addr}, 32'h11);
    chk("pass4_data", {24'd0, sif.sccb_data}, 32'h00);
    chk("pass4_entry_cnt", {24'd0, entry_cnt}, 32'd2);
    adv_snap = adv_cnt;
    repeat (40) @(negedge clk);
    chk("pass4_no_advance", adv_cnt - adv_snap, 32'd0);
    chk("pass4_writes_left", exp_q.size(), 32'd0);
    nack_left = 0;

    // Pass 5: reset while waiting for sccb_done, then a full restart.
    done_delay = 30;
    exp_q.push_back(16'h1280);
    pulse_reconfig();
    chk("reconfig_error_clear", {31'd0, error}, 32'd0);
    n = 0;
    while (state_dbg != ST_WAIT && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pass5_reached_wait", {31'd0, (state_dbg == ST_WAIT)}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("midwait_reset");
    repeat (4) @(negedge clk);
    done_delay = 2;
    lat_q.delete();
    push_table(0);
    first_delta = -1;
    mark_cyc = cyc;
    reset = 1'b0;
    wait_end("pass5", 2000);
    chk("pass5_powerup_delay", {31'd0, (first_delta >= POWERUP + 1 + SETTLE)}, 32'd1);
    chk("pass5_done", {31'd0, done}, 32'd1);
    chk("pass5_entry_cnt", {24'd0, entry_cnt}, 32'd3);
    chk("pass5_writes_left", exp_q.size(), 32'd0);
    chk("pass5_latency_left", lat_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_cfg_sequencer.md
Name: ov7670_cfg_sequencer

Overview:
Walks the OV7670 register table from power-up to the 16'hFFFF end marker. Hands each 16-bit {reg_addr, value} entry to the SCCB write engine and enforces the required delays: power-up, post-soft-reset and inter-write gaps. Retries NACKed writes. Sits between the register-table ROM (command/finished/advance/resend interface) and the SCCB master. Supports re-configuration on request.

Parameters:
CAM_ID, 8'h42, SCCB write device ID placed on sccb_id.
POWERUP_CYCLES, 1_250_000, wait after reset before first write (50 ms at 25 MHz).
RESET_WAIT_CYCLES, 25_000, wait after any COM7 write with bit7 set (1 ms at 25 MHz).
GAP_CYCLES, 250, idle cycles between consecutive writes.
MAX_RETRY, 3, NACK retries per entry before error.
SETTLE_CYCLES, 3, wait after advance/resend before sampling command (ROM latency).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
reconfig  in  1  one-cycle pulse: rerun the table from entry 0
command  in  16  ROM output: [15:8] register address, [7:0] value
finished  in  1  ROM end-of-table flag (command == 16'hFFFF)
advance  out  1  one-cycle pulse: ROM address +1
resend  out  1  held high exactly one cycle to rewind the ROM (ROM acts on the falling edge)
sccb_valid  out  1  write request to the SCCB master; held until accepted
sccb_ready  in  1  SCCB master accepts the request when valid & ready
sccb_id  out  8  device ID, constant CAM_ID
sccb_addr  out  8  register address
sccb_data  out  8  register value
sccb_done  in  1  one-cycle pulse: transaction finished
sccb_nack  in  1  qualified by sccb_done: slave did not ACK
busy  out  1  sequence in progress
done  out  1  level: table completed without error; cleared on reconfig
error  out  1  level: an entry exhausted its retries; cleared on reconfig
entry_cnt  out  8  number of entries written successfully in the current pass

Behaviour:
- Reset values: all outputs 0, except sccb_id = CAM_ID. State goes to POWERUP, counter loaded with POWERUP_CYCLES.
- States:
  - POWERUP: count down, then go to REWIND.
  - REWIND: resend=1 for one cycle, then go to SETTLE.
  - SETTLE: wait SETTLE_CYCLES, then go to CHECK.
  - CHECK: if finished, go to DONE. Otherwise latch command into sccb_addr/sccb_data, clear retry count, go to ISSUE.
  - ISSUE: sccb_valid=1. On valid & ready, drop valid the next cycle and go to WAIT.
  - WAIT: on sccb_done & !sccb_nack, increment entry_cnt and go to GAP.
    - On sccb_done & sccb_nack with retry < MAX_RETRY: retry+1, wait GAP_CYCLES, then return to ISSUE with the same entry.
    - On sccb_done & sccb_nack with retries exhausted: go to ERROR.
  - GAP: count GAP_CYCLES, or RESET_WAIT_CYCLES if sccb_addr==8'h12 and sccb_data[7]==1. Then go to NEXT.
  - NEXT: advance=1 for one cycle, then go to SETTLE.
  - DONE: done=1, busy=0.
  - ERROR: error=1, busy=0. sccb_addr/sccb_data hold the failing entry.
- busy=1 in every state except DONE and ERROR.
- Latency: for each successful entry, advance pulses exactly GAP (or RESET_WAIT) + 1 cycles after the sccb_done cycle.
- reconfig:
  - In DONE or ERROR: clear done, error and entry_cnt, then go to REWIND. POWERUP is not repeated.
  - In any busy state: ignored, except in POWERUP, where it is also ignored (no restart).
- sccb_valid never drops before acceptance. sccb_addr/sccb_data are stable while valid.
- sccb_done outside WAIT is ignored.
- advance and resend never assert in the same cycle, and neither asserts while sccb_valid=1.
- A table whose entry 0 is 16'hFFFF completes with done=1, entry_cnt=0 and no SCCB traffic.
- Reset mid-transaction returns to POWERUP immediately. The SCCB master is reset by the same signal.
- Counters are sized as $clog2 of the largest delay parameter + 1. entry_cnt saturates at 255.

Decomposition:
- Shared package ov7670_cfg_pkg:
  - state enum.
  - COM7_ADDR = 8'h12, COM7_RESET_BIT = 7.
  - CFG_END = 16'hFFFF.
  - SCCB_WRITE_ID = 8'h42.
- One sub-module, cfg_delay_timer: load value, start pulse, expired flag. Shared by the POWERUP, SETTLE and GAP waits.

Test Plan:
Use POWERUP=10, RESET_WAIT=20, GAP=4, MAX_RETRY=2, with a 4-entry model ROM {1280, 1204, 1100, FFFF} and an ACKing SCCB model.
- Reset release -> first sccb_valid no earlier than 10+1+3 cycles. Writes in order: 12/80, 12/04, 11/00. done=1, entry_cnt=3.
- Entry 12/80 -> next advance exactly 21 cycles after its sccb_done. Entry 12/04 -> next advance exactly 5 cycles after its sccb_done.
- SCCB model holds ready low for 7 cycles -> sccb_valid stays high with addr/data stable for 7 cycles; exactly one transaction.
- Entry 11/00 NACKs twice, then ACKs -> 3 transactions to 11/00, done=1. NACK 3 times -> error=1, sccb_addr=11, entry_cnt=2, no further advance.
- reconfig pulse in DONE -> resend high for one cycle, done clears, all 3 writes repeat, no POWERUP delay. reconfig while busy -> no effect.
- Reset asserted mid-WAIT -> all outputs 0 in the same cycle. Full sequence restarts with POWERUP after release.
